// File: rtl/iob_spi_fl_prefetch_pkg.sv
// Shared definitions for the SPI flash read-prefetch stage: fetch engine
// states, the word increment and parameter defaults.
package iob_spi_fl_prefetch_pkg;

  typedef enum logic {
    F_IDLE = 1'b0,
    F_BUSY = 1'b1
  } fetch_state_t;

  localparam int WORD_INC       = 4;
  localparam int DEFAULT_ADDR_W = 24;
  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 4;

endpackage

// File: rtl/iob_spi_fl_pf_fifo.sv
// Circular word buffer for the prefetch stage: push, pop and flush with an
// occupancy count. Flush wins over a simultaneous push or pop.
module iob_spi_fl_pf_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  output logic [DATA_W-1:0]      head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; count guards every read of it.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/iob_spi_fl_prefetch.sv
// Sequential read-prefetch stage in front of the SPI flash master core.
// FL_PREFETCH_EN enables speculative fetching; without it every read is one flash op.
module iob_spi_fl_prefetch
  import iob_spi_fl_prefetch_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_cache,
  input  logic [ADDR_W-1:0]   address_cache,
  input  logic [DATA_W/8-1:0] wstrb_cache,
  output logic [DATA_W-1:0]   rdata_cache,
  output logic                ready_cache,
  output logic [31:0]         fl_address,
  output logic                fl_valid,
  input  logic [DATA_W-1:0]   fl_rdata,
  input  logic                fl_ready,
  input  logic                sw_hold
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(WORD_INC);

  fetch_state_t state, state_next;

  logic [ADDR_W-1:0] head_addr;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] fl_addr_q;
  logic [ADDR_W-1:0] req_word;
  logic              pending;
  logic              discard;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] head_data;
  logic              is_write;
  logic              accept;
  logic              hit;
  logic              miss;
  logic              serve;
  logic              pop;
  logic              push;
  logic              fl_done;
  logic              prefetch_ok;
  logic              start;
  logic              unused_ok;
`ifdef FL_PREFETCH_EN
  logic              primed;
`endif

  assign req_word  = {address_cache[ADDR_W-1:2], 2'b00};
  assign is_write  = |wstrb_cache;
  assign accept    = valid_cache && !ready_cache && !pending;
  assign hit       = accept && !is_write && (count != '0) && (req_word == head_addr);
  assign miss      = accept && !is_write && !hit;
  assign serve     = pending && (count != '0);
  assign pop       = hit || serve;
  assign fl_done   = (state == F_BUSY) && fl_ready;
  assign push      = fl_done && !discard;
  assign unused_ok = ^address_cache[1:0];

  // Without prefetch the buffer is empty between requests, so every read misses.
`ifdef FL_PREFETCH_EN
  assign prefetch_ok = primed && (count < CNT_W'(DEPTH));
`else
  assign prefetch_ok = 1'b0;
`endif

  // A miss in this cycle retargets fetch_addr, so starting waits one cycle.
  assign start = !sw_hold && !miss && ((pending && (count == '0)) || prefetch_ok);

  assign fl_valid   = (state == F_BUSY);
  assign fl_address = 32'(fl_addr_q);

  iob_spi_fl_pf_fifo #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (miss),
    .push     (push),
    .push_data(fl_rdata),
    .pop      (pop),
    .head_data(head_data),
    .count    (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= F_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      F_IDLE:  if (start)    state_next = F_BUSY;
      F_BUSY:  if (fl_ready) state_next = F_IDLE;
      default: state_next = F_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_cache <= 1'b0;
      rdata_cache <= '0;
      head_addr   <= '0;
      fetch_addr  <= '0;
      fl_addr_q   <= '0;
      pending     <= 1'b0;
      discard     <= 1'b0;
`ifdef FL_PREFETCH_EN
      primed      <= 1'b0;
`endif
    end else begin
      ready_cache <= 1'b0;
      rdata_cache <= '0;
      if (accept && is_write) begin
        ready_cache <= 1'b1;
      end else if (pop) begin
        ready_cache <= 1'b1;
        rdata_cache <= head_data;
        head_addr   <= head_addr + INC;
      end
      if (serve) pending <= 1'b0;
      if ((state == F_IDLE) && start) fl_addr_q <= fetch_addr;
      // An op still in flight at a miss returns a stale word that must be dropped.
      if (miss) begin
        head_addr  <= req_word;
        fetch_addr <= req_word;
        pending    <= 1'b1;
        discard    <= (state == F_BUSY) && !fl_ready;
`ifdef FL_PREFETCH_EN
        primed     <= 1'b1;
`endif
      end else if (fl_done) begin
        if (discard) discard    <= 1'b0;
        else         fetch_addr <= fetch_addr + INC;
      end
    end
  end

endmodule

// File: tb/tb_iob_spi_fl_prefetch.sv
// Scoreboard bench for iob_spi_fl_prefetch: a flash model answers ops, a monitor
// checks every cache response against a memory image and latency rules.
module tb_iob_spi_fl_prefetch;

  logic        clk;
  logic        rst;
  logic        valid_cache;
  logic [23:0] address_cache;
  logic [3:0]  wstrb_cache;
  logic [31:0] rdata_cache;
  logic        ready_cache;
  logic [31:0] fl_address;
  logic        fl_valid;
  logic [31:0] fl_rdata;
  logic        fl_ready;
  logic        sw_hold;

  typedef struct {
    logic [31:0] data;
    int          kind;
    int          sample;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_fl_q[$];
  logic [31:0] fl_log[$];

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int flr_cycle = -100;
  int fl_lat = 3;

  iob_spi_fl_prefetch dut (
    .clk          (clk),
    .rst          (rst),
    .valid_cache  (valid_cache),
    .address_cache(address_cache),
    .wstrb_cache  (wstrb_cache),
    .rdata_cache  (rdata_cache),
    .ready_cache  (ready_cache),
    .fl_address   (fl_address),
    .fl_valid     (fl_valid),
    .fl_rdata     (fl_rdata),
    .fl_ready     (fl_ready),
    .sw_hold      (sw_hold)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, tests=%0d", tests_run);
    $fatal(1, "[TB] watchdog");
  end

  // Flash contents: a fixed scramble of the byte address.
  function automatic logic [31:0] flash_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC3A51E0F;
  endfunction

  function automatic int read_kind(input int pf_kind);
`ifdef FL_PREFETCH_EN
    return pf_kind;
`else
    return 2;
`endif
  endfunction

  function automatic int find_from(input int from, input logic [31:0] a);
    for (int i = from; i < fl_log.size(); i++) if (fl_log[i] == a) return i;
    return -1;
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (i >= 0 && i < fl_log.size()) return fl_log[i];
    return 32'hDEADBEEF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input bit is_write, input logic [23:0] addr, input int kind);
    exp_t        e;
    int          waited;
    logic [23:0] word;
    @(posedge clk);
    #1;
    word     = {addr[23:2], 2'b00};
    e.data   = is_write ? 32'h0 : flash_word(32'(word));
    e.kind   = kind;
    e.sample = cyc;
    exp_q.push_back(e);
`ifndef FL_PREFETCH_EN
    if (!is_write) exp_fl_q.push_back(32'(word));
`endif
    valid_cache   = 1'b1;
    address_cache = word | 24'($urandom_range(0, 3));
    wstrb_cache   = is_write ? 4'($urandom_range(1, 15)) : 4'h0;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!ready_cache && waited < 1000);
    if (!ready_cache) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL response_timeout: no ready_cache for addr %h after %0d cycles", addr, waited);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    valid_cache = 1'b0;
    wstrb_cache = 4'h0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Flash core model: one op at a time, fixed or random latency, 1-cycle fl_ready.
  initial begin
    int          remain;
    bit          busy;
    logic [31:0] cur;
    fl_ready = 1'b0;
    fl_rdata = '0;
    busy     = 1'b0;
    remain   = 0;
    cur      = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        fl_ready = 1'b0;
        busy     = 1'b0;
      end else if (fl_ready) begin
        fl_ready = 1'b0;
      end else if (busy) begin
        if (remain > 1) begin
          remain--;
        end else begin
          checkOutput("fl_address_stable", fl_address, cur);
          fl_rdata  = flash_word(cur);
          fl_ready  = 1'b1;
          flr_cycle = cyc;
          busy      = 1'b0;
        end
      end else if (fl_valid) begin
        cur = fl_address;
        fl_log.push_back(cur);
        busy   = 1'b1;
        remain = (fl_lat == 0) ? int'($urandom_range(1, 8)) : fl_lat;
`ifndef FL_PREFETCH_EN
        if (exp_fl_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_fl_op: op at %h with no read outstanding", cur);
        end else begin
          checkOutput("fl_op_addr", cur, exp_fl_q.pop_front());
        end
`endif
      end
    end
  end

  // Response monitor: pops the scoreboard on every ready_cache pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ready_cache) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_response: ready_cache with empty scoreboard, rdata %h", rdata_cache);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rdata_cache", rdata_cache, e.data);
          if (e.kind == 1)      checkOutput("hit_latency", 32'(cyc), 32'(e.sample + 1));
          else if (e.kind == 2) checkOutput("miss_latency", 32'(cyc), 32'(flr_cycle + 2));
        end
      end
    end
  end

  initial begin
    int          idx;
    int          n0;
    int          waited;
    int          rises;
    logic [23:0] last_addr;
    logic [23:0] a;

    rst = 1'b1;
    valid_cache = 1'b0;
    address_cache = '0;
    wstrb_cache = '0;
    sw_hold = 1'b0;
    wait_cycles(3);
    checkOutput("reset_ready", 32'(ready_cache), 0);
    checkOutput("reset_rdata", rdata_cache, 0);
    checkOutput("reset_fl_valid", 32'(fl_valid), 0);
    checkOutput("reset_fl_address", fl_address, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    wait_cycles(10);
    checkOutput("idle_before_first_read", 32'(fl_log.size()), 0);

    // Cold read and the sequential prefetch run that follows it.
    fl_lat = 20;
    applyStimulus(1'b0, 24'h000100, 2);
    checkOutput("cold_fl_address", log_at(0), 32'h100);
    fl_lat = 2;
    wait_cycles(100);
`ifdef FL_PREFETCH_EN
    checkOutput("prefetch_op_count", 32'(fl_log.size()), 5);
    for (int i = 1; i < 5; i++) checkOutput("prefetch_addr", log_at(i), 32'h100 + 32'(4 * i));
`else
    checkOutput("no_speculative_fetch", 32'(fl_log.size()), 1);
`endif

    fl_lat = 30;
    applyStimulus(1'b0, 24'h000104, read_kind(1));
    applyStimulus(1'b0, 24'h000108, read_kind(1));
`ifdef FL_PREFETCH_EN
    checkOutput("refill_after_pop", log_at(5), 32'h114);
    idx = find_from(0, 32'h114);
    applyStimulus(1'b0, 24'h002000, 2);
    checkOutput("discard_then_refetch", log_at(idx + 1), 32'h2000);
`else
    applyStimulus(1'b0, 24'h002000, 2);
`endif

    // Address wrap at the top of the 24-bit window.
    fl_lat = 2;
    wait_cycles(150);
    n0 = fl_log.size();
    applyStimulus(1'b0, 24'hFFFFF8, 2);
    wait_cycles(60);
`ifdef FL_PREFETCH_EN
    idx = find_from(n0, 32'hFFFFF8);
    checkOutput("wrap_prefetch_fffffc", log_at(idx + 1), 32'hFFFFFC);
    checkOutput("wrap_prefetch_zero", log_at(idx + 2), 32'h0);
`endif
    applyStimulus(1'b0, 24'hFFFFFC, read_kind(1));
    applyStimulus(1'b0, 24'h000000, read_kind(1));

    // Writes, including one while a fetch is in flight.
    wait_cycles(40);
    fl_lat = 25;
    applyStimulus(1'b0, 24'h000004, read_kind(1));
`ifdef FL_PREFETCH_EN
    checkOutput("fetch_busy_at_write", 32'(fl_valid), 1);
`endif
    applyStimulus(1'b1, 24'h000008, 1);
    applyStimulus(1'b0, 24'h000008, read_kind(1));
    applyStimulus(1'b1, 24'h123454, 1);

    // sw_hold blocks new flash ops.
    sw_hold = 1'b1;
    waited = 0;
    while (fl_valid && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    fork
      applyStimulus(1'b0, 24'h000300, 2);
      begin
        rises = 0;
        repeat (30) begin
          @(negedge clk);
          if (fl_valid) rises++;
        end
        checkOutput("sw_hold_blocks", 32'(rises), 0);
        @(posedge clk);
        #1 sw_hold = 1'b0;
      end
    join

    // Reset in the middle of a flash op.
    fl_lat = 40;
    @(posedge clk);
    #1;
`ifndef FL_PREFETCH_EN
    exp_fl_q.push_back(32'h500);
`endif
    valid_cache = 1'b1;
    address_cache = 24'h000500;
    wstrb_cache = 4'h0;
    waited = 0;
    while (!fl_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("fl_valid_before_reset", 32'(fl_valid), 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("midop_reset_fl_valid", 32'(fl_valid), 0);
    checkOutput("midop_reset_fl_address", fl_address, 0);
    checkOutput("midop_reset_ready", 32'(ready_cache), 0);
    checkOutput("midop_reset_rdata", rdata_cache, 0);
    valid_cache = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    exp_fl_q.delete();
    fl_lat = 3;
    n0 = fl_log.size();
    applyStimulus(1'b0, 24'h000040, 2);
    applyStimulus(1'b0, 24'h000040, 2);
`ifndef FL_PREFETCH_EN
    checkOutput("two_reads_two_ops", 32'(fl_log.size() - n0), 2);
`endif

    // Randomized traffic against the flash memory image.
    fl_lat = 0;
    last_addr = 24'h000040;
    for (int t = 0; t < 120; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        sw_hold = 1'b1;
        wait_cycles(int'($urandom_range(1, 10)));
        sw_hold = 1'b0;
      end
      case ($urandom_range(0, 9))
        0, 1: applyStimulus(1'b1, 24'($urandom), 1);
        2, 3, 4, 5, 6: begin
          last_addr = last_addr + 24'd4;
          applyStimulus(1'b0, last_addr, read_kind(0));
        end
        default: begin
          a = ($urandom_range(0, 3) == 0) ? 24'hFFFFF0 + 24'($urandom_range(0, 15))
                                          : 24'($urandom);
          last_addr = {a[23:2], 2'b00};
          applyStimulus(1'b0, last_addr, read_kind(0));
        end
      endcase
    end

    wait_cycles(20);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 0);
`ifndef FL_PREFETCH_EN
    checkOutput("fl_ops_drained", 32'(exp_fl_q.size()), 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
